// File: rtl/readout_pkg.sv
// Shared types and helpers for the readout feature framer: FSM state,
// derived widths and the saturating offset-binary quantizer.
package readout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Accumulator width: a full bin of DECIM samples can never overflow it.
    function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned decim);
        return in_w + $clog2(decim);
    endfunction

    function automatic int unsigned vec_w(input int unsigned nbins, input int unsigned qbits);
        return 2 * nbins * qbits;
    endfunction

    // Shift, clamp to the signed QBITS range, then re-bias to 0..2^QBITS-1.
    function automatic logic [31:0] quantize(input logic signed [63:0] avg,
                                             input int unsigned       qshift,
                                             input int unsigned       qbits);
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        q  = avg >>> qshift;
        hi = (64'sd1 <<< (qbits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (qbits - 1));
        if (q > hi) begin
            q = hi;
        end else if (q < lo) begin
            q = lo;
        end
        return 32'(q - lo);
    endfunction

endpackage

// File: rtl/readout_feature_framer_if.sv
// Sample-in / feature-vector-out bundle of the readout feature framer.
interface readout_feature_framer_if #(
    parameter int unsigned IN_W  = 14,
    parameter int unsigned VEC_W = 64
);
    logic                    shot_start;
    logic                    s_valid;
    logic signed [IN_W-1:0]  s_i;
    logic signed [IN_W-1:0]  s_q;
    logic                    m_valid;
    logic                    m_ready;
    logic [VEC_W-1:0]        m_data;
    logic                    shot_drop;
    logic                    busy;

    modport master (
        output shot_start, s_valid, s_i, s_q, m_ready,
        input  m_valid, m_data, shot_drop, busy
    );

    modport slave (
        input  shot_start, s_valid, s_i, s_q, m_ready,
        output m_valid, m_data, shot_drop, busy
    );
endinterface

// File: rtl/bin_quantizer.sv
// Boxcar accumulator for one channel; on the last sample of a bin it
// registers the quantized bin average and reseeds for the next bin.
module bin_quantizer
    import readout_pkg::*;
#(
    parameter int unsigned IN_W   = 14,
    parameter int unsigned DECIM  = 8,
    parameter int unsigned QBITS  = 2,
    parameter int unsigned QSHIFT = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   seed,
    input  logic                   add,
    input  logic                   last,
    input  logic signed [IN_W-1:0] sample,
    output logic [QBITS-1:0]       code
);
    localparam int unsigned ACC_W = acc_w(IN_W, DECIM);
    localparam int unsigned LOG2D = $clog2(DECIM);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] avg_c;

    assign sum_c = acc + ACC_W'(sample);
    assign avg_c = sum_c >>> LOG2D;

    // clr has priority so a restarting shot can seed with its first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            code <= '0;
        end else if (clr) begin
            acc <= seed ? ACC_W'(sample) : '0;
        end else if (add) begin
            if (last) begin
                acc  <= '0;
                code <= QBITS'(quantize(64'(avg_c), QSHIFT, QBITS));
            end else begin
                acc <= sum_c;
            end
        end
    end

endmodule

// File: rtl/readout_feature_framer.sv
// Bins the I/Q sample stream of one readout shot into NBINS quantized
// features and presents the packed vector over a valid/ready handshake.
module readout_feature_framer
    import readout_pkg::*;
#(
    parameter int unsigned IN_W   = 14,
    parameter int unsigned DECIM  = 8,
    parameter int unsigned NBINS  = 16,
    parameter int unsigned QBITS  = 2,
    parameter int unsigned QSHIFT = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    readout_feature_framer_if.slave bus
);
    localparam int unsigned VEC_W = vec_w(NBINS, QBITS);
    localparam int unsigned CNT_W = $clog2(DECIM);
    localparam int unsigned BIN_W = (NBINS > 1) ? $clog2(NBINS) : 1;

    state_e             state;
    state_e             state_d;
    logic [CNT_W-1:0]   samp_cnt;
    logic [BIN_W-1:0]   bin_cnt;
    logic               clr_c;
    logic               seed_c;
    logic               add_c;
    logic               last_c;
    logic               pack_pend;
    logic [BIN_W-1:0]   pack_bin;
    logic [QBITS-1:0]   code_i;
    logic [QBITS-1:0]   code_q;
    logic               m_valid_r;
    logic [VEC_W-1:0]   m_data_r;
    logic               shot_drop_r;
    logic               busy_r;

    assign bus.m_valid   = m_valid_r;
    assign bus.m_data    = m_data_r;
    assign bus.shot_drop = shot_drop_r;
    assign bus.busy      = busy_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus datapath strobes; outside ACCUM the accumulators are held clear.
    always_comb begin
        state_d = state;
        clr_c   = 1'b1;
        seed_c  = 1'b0;
        add_c   = 1'b0;
        last_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.shot_start) begin
                    state_d = ACCUM;
                    seed_c  = bus.s_valid;
                end
            end
            ACCUM: begin
                clr_c  = bus.shot_start;
                seed_c = bus.shot_start && bus.s_valid;
                add_c  = !bus.shot_start && bus.s_valid;
                last_c = add_c && (samp_cnt == CNT_W'(DECIM - 1));
                if (last_c && (bin_cnt == BIN_W'(NBINS - 1))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (m_valid_r && bus.m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample and bin counters; a seeded restart has already consumed sample 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt  <= '0;
            bin_cnt   <= '0;
            pack_pend <= 1'b0;
            pack_bin  <= '0;
        end else begin
            pack_pend <= last_c;
            pack_bin  <= bin_cnt;
            if (clr_c) begin
                samp_cnt <= seed_c ? CNT_W'(1) : '0;
                bin_cnt  <= '0;
            end else if (add_c) begin
                if (last_c) begin
                    samp_cnt <= '0;
                    bin_cnt  <= (bin_cnt == BIN_W'(NBINS - 1)) ? '0 : bin_cnt + BIN_W'(1);
                end else begin
                    samp_cnt <= samp_cnt + CNT_W'(1);
                end
            end
        end
    end

    bin_quantizer #(
        .IN_W   (IN_W),
        .DECIM  (DECIM),
        .QBITS  (QBITS),
        .QSHIFT (QSHIFT)
    ) u_quant_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_c),
        .seed   (seed_c),
        .add    (add_c),
        .last   (last_c),
        .sample (bus.s_i),
        .code   (code_i)
    );

    bin_quantizer #(
        .IN_W   (IN_W),
        .DECIM  (DECIM),
        .QBITS  (QBITS),
        .QSHIFT (QSHIFT)
    ) u_quant_q (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_c),
        .seed   (seed_c),
        .add    (add_c),
        .last   (last_c),
        .sample (bus.s_q),
        .code   (code_q)
    );

    // Codes land one cycle after their bin closes, so the last bin and m_valid arrive together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r <= '0;
        end else begin
            for (int b = 0; b < int'(NBINS); b++) begin
                if (pack_pend && (pack_bin == BIN_W'(b))) begin
                    m_data_r[(2 * b) * int'(QBITS) +: QBITS]     <= code_i;
                    m_data_r[(2 * b + 1) * int'(QBITS) +: QBITS] <= code_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r   <= 1'b0;
            shot_drop_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            m_valid_r   <= (state == HOLD) && (state_d == HOLD);
            shot_drop_r <= (state == HOLD) && bus.shot_start;
            busy_r      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_readout_feature_framer.sv
// Scoreboard bench for readout_feature_framer: directed shots push expected
// vectors, a negedge monitor pops and checks them when m_valid rises.
module tb_readout_feature_framer;

    localparam int unsigned IN_W   = 14;
    localparam int unsigned DECIM  = 4;
    localparam int unsigned NBINS  = 2;
    localparam int unsigned QBITS  = 2;
    localparam int unsigned QSHIFT = 10;
    localparam int unsigned VEC_W  = 2 * NBINS * QBITS;

    typedef struct {
        logic [VEC_W-1:0] data;
        int               rise;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    exp_t             sb[$];
    exp_t             e;
    int               checks   = 0;
    int               errors   = 0;
    int               cyc      = 0;
    int               last_cyc = 0;
    int               drops    = 0;
    int               d0       = 0;
    logic             prev_v   = 1'b0;
    logic             hs_prev  = 1'b0;
    logic [VEC_W-1:0] held     = '0;

    readout_feature_framer_if #(.IN_W(IN_W), .VEC_W(VEC_W)) bus ();

    readout_feature_framer #(
        .IN_W   (IN_W),
        .DECIM  (DECIM),
        .NBINS  (NBINS),
        .QBITS  (QBITS),
        .QSHIFT (QSHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop on m_valid rise, then check stability and the post-handshake drop.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v  = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) check("m_valid_falls", 64'(bus.m_valid), 64'd0);
            if (bus.m_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vector: got %0h expected none", bus.m_data);
                end else begin
                    e = sb.pop_front();
                    check("m_data", 64'(bus.m_data), 64'(e.data));
                    check("latency", 64'(cyc), 64'(e.rise));
                end
                held = bus.m_data;
            end else if (bus.m_valid) begin
                check("m_data_stable", 64'(bus.m_data), 64'(held));
            end
            if (bus.shot_drop) drops++;
            hs_prev = bus.m_valid && bus.m_ready;
            prev_v  = bus.m_valid;
        end
    end

    task automatic drive(input logic st, input logic v,
                         input logic signed [IN_W-1:0] i, input logic signed [IN_W-1:0] q);
        @(posedge clk);
        #1;
        bus.shot_start = st;
        bus.s_valid    = v;
        bus.s_i        = i;
        bus.s_q        = q;
        if (v) last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, '0);
    endtask

    // One shot: bin 0 gets (i0,q0), bin 1 gets (i1,q1), gap idle cycles between samples.
    task automatic run_shot(input logic signed [IN_W-1:0] i0, input logic signed [IN_W-1:0] q0,
                            input logic signed [IN_W-1:0] i1, input logic signed [IN_W-1:0] q1,
                            input int gap, input logic [VEC_W-1:0] exp_data);
        exp_t x;
        for (int n = 0; n < int'(2 * DECIM); n++) begin
            drive(n == 0, 1'b1, (n < int'(DECIM)) ? i0 : i1, (n < int'(DECIM)) ? q0 : q1);
            if (gap > 0 && n < int'(2 * DECIM) - 1) idle(gap);
        end
        x.data = exp_data;
        x.rise = last_cyc + 2;
        sb.push_back(x);
        idle(1);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while ((bus.busy || bus.m_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, 64'(bus.busy || bus.m_valid), 64'd0);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!bus.m_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid"}, 64'(bus.m_valid), 64'd1);
    endtask

    initial begin
        bus.shot_start = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_i        = '0;
        bus.s_q        = '0;
        bus.m_ready    = 1'b1;
        #12;
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_m_data", 64'(bus.m_data), 64'd0);
        check("rst_shot_drop", 64'(bus.shot_drop), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Basic saturation in both directions
        run_shot(14'sd2048, -14'sd2048, 14'sd2048, -14'sd2048, 0, 8'h33);
        wait_done("t1");
        // Floor and saturation edges
        run_shot(14'sd0, 14'sd1023, 14'sd0, 14'sd1023, 0, 8'hAA);
        wait_done("t2a");
        run_shot(-14'sd1, 14'sd1024, -14'sd1, 14'sd1024, 0, 8'hDD);
        wait_done("t2b");
        // Distinct bins check packing order
        run_shot(14'sd2048, -14'sd2048, 14'sd0, 14'sd0, 0, 8'hA3);
        wait_done("order");

        // Backpressure in HOLD with ignored samples and a rejected start
        bus.m_ready = 1'b0;
        run_shot(14'sd2048, -14'sd2048, 14'sd2048, -14'sd2048, 0, 8'h33);
        wait_valid("t3");
        d0 = drops;
        for (int k = 0; k < 5; k++) drive(k == 2, 1'b1, 14'sd100, -14'sd100);
        idle(1);
        @(negedge clk);
        #1;
        check("t3_one_drop", 64'(drops - d0), 64'd1);
        check("t3_still_valid", 64'(bus.m_valid), 64'd1);
        check("t3_still_busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        bus.m_ready    = 1'b1;
        bus.shot_start = 1'b1;
        @(posedge clk);
        #1 bus.shot_start = 1'b0;
        @(negedge clk);
        #1;
        check("t3_hs_drop", 64'(drops - d0), 64'd2);
        check("t3_idle_after_hs", 64'(bus.busy), 64'd0);
        idle(2);

        // Abort after three large samples; they must not reach the bin
        drive(1'b1, 1'b1, 14'sd4095, 14'sd0);
        drive(1'b0, 1'b1, 14'sd4095, 14'sd0);
        drive(1'b0, 1'b1, 14'sd4095, 14'sd0);
        run_shot(14'sd0, 14'sd0, 14'sd0, 14'sd0, 0, 8'hAA);
        wait_done("t4");

        // Sparse valid: one sample every third cycle
        run_shot(14'sd2048, -14'sd2048, 14'sd2048, -14'sd2048, 2, 8'h33);
        wait_done("t5");

        // Reset mid-ACCUM
        for (int k = 0; k < 5; k++) drive(k == 0, 1'b1, 14'sd2048, 14'sd2048);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        check("t6_busy_async", 64'(bus.busy), 64'd0);
        check("t6_valid_async", 64'(bus.m_valid), 64'd0);
        check("t6_data_async", 64'(bus.m_data), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        check("t6_idle_after_rst", 64'(bus.busy || bus.m_valid), 64'd0);
        run_shot(-14'sd1, 14'sd1024, -14'sd1, 14'sd1024, 0, 8'hDD);
        wait_done("t6");

        idle(5);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
